// File: rtl/aes_dec_stream_ctrl.sv
// Purpose : AES decryption stream controller. It sequences key expansion, holds the
//           round-key file, and iterates an external combinational inverse-round core NR times per block.
// Latency : input handshake to out_r_TVALID is NR+1 cycles; one block every NR+2 cycles with no backpressure.
// Backpressure: the output block is held in OUT until out_r_TREADY; in_r_TREADY is only high in LOAD.
//
// Ports:
//   ap_clk, ap_rst                 clock; asynchronous active-high reset
//   ap_start/ap_done/ap_idle/ap_ready  job control (ap_ready and ap_done are one-cycle pulses)
//   key, num_blocks                job parameters, latched when the job is accepted
//   in_r_*  / out_r_*              128-bit ciphertext in and plaintext out, AXI-stream style
//   ke_*                           external key expander: start pulse and key out; indexed round-key writes and done in
//   rd_*                           external inverse-round core: state, round key and final flag out; result in
// Build option: define AES_DEC_KEY_CACHE_EN to skip key expansion when the job key equals
//               the last fully expanded key.
module aes_dec_stream_ctrl #(
    parameter int KEY_BITS = 192,
    parameter int CNT_W    = 16
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    input  logic [KEY_BITS-1:0] key,
    input  logic [CNT_W-1:0]    num_blocks,
    input  logic [127:0]        in_r_TDATA,
    input  logic                in_r_TVALID,
    output logic                in_r_TREADY,
    output logic [127:0]        out_r_TDATA,
    output logic                out_r_TVALID,
    input  logic                out_r_TREADY,
    output logic                ke_start,
    output logic [KEY_BITS-1:0] ke_key,
    input  logic                ke_rk_valid,
    input  logic [3:0]          ke_rk_idx,
    input  logic [127:0]        ke_rk_data,
    input  logic                ke_done,
    output logic [127:0]        rd_din,
    output logic [127:0]        rd_rk,
    output logic                rd_final,
    input  logic [127:0]        rd_dout
);
    localparam int         NR   = (KEY_BITS == 128) ? 10 : (KEY_BITS == 256) ? 14 : 12;
    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [2:0] {
        S_IDLE, S_KEXP, S_LOAD, S_ROUND, S_OUT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [CNT_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [127:0]        dat_q, dat_d;
    logic                ready_q, ready_d;
    logic                ke_start_q, ke_start_d;
    logic                cache_hit;

    // Round-key file: sized to the 4-bit index space; entries above NR are never written.
    logic [127:0]        rk_q [16];

`ifdef AES_DEC_KEY_CACHE_EN
    logic [KEY_BITS-1:0] ckey_q, ckey_d;
    logic                cvld_q, cvld_d;
    // The live key input is what gets latched this cycle, so compare against it directly.
    assign cache_hit = cvld_q && (key == ckey_q);
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        blk_cnt_d = blk_cnt_q;
        rnd_d     = rnd_q;
        dat_d     = dat_q;
        ready_d   = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
        ckey_d    = ckey_q;
        cvld_d    = cvld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    key_d     = key;
                    blk_cnt_d = num_blocks;
                    ready_d   = 1'b1;
                    if (num_blocks == '0) begin
                        state_d = S_DONE;
                    end else if (cache_hit) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_KEXP;
`ifdef AES_DEC_KEY_CACHE_EN
                        // The round-key file is about to be overwritten.
                        cvld_d  = 1'b0;
`endif
                    end
                end
            end
            S_KEXP: begin
                if (ke_done) begin
                    state_d = S_LOAD;
`ifdef AES_DEC_KEY_CACHE_EN
                    ckey_d  = key_q;
                    cvld_d  = 1'b1;
`endif
                end
            end
            S_LOAD: begin
                if (in_r_TVALID) begin
                    dat_d   = in_r_TDATA ^ rk_q[NR_L];
                    rnd_d   = NR_L - 4'd1;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                dat_d = rd_dout;
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd0) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_r_TREADY) begin
                    blk_cnt_d = blk_cnt_q - CNT_W'(1);
                    state_d   = (blk_cnt_q > CNT_W'(1)) ? S_LOAD : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Expander start is high only in the first KEXP cycle.
        ke_start_d = (state_d == S_KEXP) && (state_q != S_KEXP);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            blk_cnt_q  <= '0;
            rnd_q      <= '0;
            dat_q      <= '0;
            ready_q    <= 1'b0;
            ke_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            blk_cnt_q  <= blk_cnt_d;
            rnd_q      <= rnd_d;
            dat_q      <= dat_d;
            ready_q    <= ready_d;
            ke_start_q <= ke_start_d;
        end
    end

`ifdef AES_DEC_KEY_CACHE_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ckey_q <= '0;
            cvld_q <= 1'b0;
        end else begin
            ckey_q <= ckey_d;
            cvld_q <= cvld_d;
        end
    end
`endif

    // Key material needs no reset; it is always rewritten or validated before use.
    always_ff @(posedge ap_clk) begin
        if ((state_q == S_KEXP) && ke_rk_valid && (ke_rk_idx <= NR_L)) begin
            rk_q[ke_rk_idx] <= ke_rk_data;
        end
    end

    assign ap_idle      = (state_q == S_IDLE);
    assign ap_done      = (state_q == S_DONE);
    assign ap_ready     = ready_q;
    assign ke_start     = ke_start_q;
    assign ke_key       = key_q;
    assign in_r_TREADY  = (state_q == S_LOAD);
    assign out_r_TVALID = (state_q == S_OUT);
    assign out_r_TDATA  = dat_q;
    assign rd_din       = dat_q;
    assign rd_rk        = rk_q[rnd_q];
    assign rd_final     = (rnd_q == 4'd0);

endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
module tb_aes_dec_stream_ctrl;
    localparam int CNT_W = 16;
    localparam logic [255:0] FKEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;

    logic             ap_clk = 1'b0;
    logic             ap_rst = 1'b1;
    logic             ap_start = 1'b0;
    logic [255:0]     key_in = '0;
    logic [CNT_W-1:0] num_blocks = '0;
    logic [127:0]     in_dat = '0;
    logic             in_vld = 1'b0;
    logic             out_rdy = 1'b0;
    logic [2:0]       done_v, idle_v, ready_v, trdy_v, ovld_v, kst_v;
    logic [127:0]     odat_v [3];
    int               sel = 1;

    int vec = 0, err = 0;
    int kst_cnt, done_cnt, ready_cnt, steps = 0, first_done;
    bit trdy_seen;
    logic [127:0] ct_q[$];
    logic [127:0] exp_q[$];
    logic [255:0] cm_key [3];
    bit           cm_vld [3];

    always #5 ap_clk = ~ap_clk;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00; x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] t, r;
        t = a; r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r;
    endfunction
    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = ginv(a);
        return i ^ rl(i, 1) ^ rl(i, 2) ^ rl(i, 3) ^ rl(i, 4) ^ 8'h63;
    endfunction
    function automatic logic [7:0] isbox(input logic [7:0] a);
        return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
    endfunction
    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction
    // Round key idx of a left-aligned key of nk 32-bit words.
    function automatic logic [127:0] rk_of(input logic [255:0] k, input int nk, input int idx);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < nk) begin
                w[i] = k[255-32*i -: 32];
            end else begin
                tmp = w[i-1];
                if (i % nk == 0) begin
                    tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                    rc  = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    tmp = subw(tmp);
                end
                w[i] = w[i-nk] ^ tmp;
            end
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk, input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = isbox(b[4*((c-r+4)%4)+r]) ^ rk[127-8*(4*c+r) -: 8];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (fin) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {
                    gmul(a0,8'd14) ^ gmul(a1,8'd11) ^ gmul(a2,8'd13) ^ gmul(a3,8'd9),
                    gmul(a0,8'd9)  ^ gmul(a1,8'd14) ^ gmul(a2,8'd11) ^ gmul(a3,8'd13),
                    gmul(a0,8'd13) ^ gmul(a1,8'd9)  ^ gmul(a2,8'd14) ^ gmul(a3,8'd11),
                    gmul(a0,8'd11) ^ gmul(a1,8'd13) ^ gmul(a2,8'd9)  ^ gmul(a3,8'd14)};
            end
        end
        return o;
    endfunction
    function automatic logic [127:0] aes_dec_ref(input logic [127:0] ct, input logic [255:0] k, input int nk);
        logic [127:0] s;
        s = ct ^ rk_of(k, nk, nk + 6);
        for (int r = nk + 5; r >= 0; r--) s = inv_round(s, rk_of(k, nk, r), r == 0);
        return s;
    endfunction
    function automatic logic [255:0] kview(input logic [255:0] k, input int s);
        return k >> (128 - 64*s);
    endfunction
    function automatic logic [255:0] rand256();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- DUTs for 128/192/256-bit keys with expander and core models ----------------
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int KB  = 128 + 64*g;
        localparam int NRG = KB/32 + 6;
        logic          start_g, ke_start_g, ke_rk_valid_g, ke_done_g, rd_final_g;
        logic [KB-1:0] ke_key_g;
        logic [3:0]    ke_rk_idx_g;
        logic [127:0]  ke_rk_data_g, rd_din_g, rd_rk_g, rd_dout_g;

        assign start_g  = ap_start && (sel == g);
        assign kst_v[g] = ke_start_g;

        aes_dec_stream_ctrl #(.KEY_BITS(KB), .CNT_W(CNT_W)) u_dut (
            .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(start_g),
            .ap_done(done_v[g]), .ap_idle(idle_v[g]), .ap_ready(ready_v[g]),
            .key(key_in[255 -: KB]), .num_blocks(num_blocks),
            .in_r_TDATA(in_dat), .in_r_TVALID(in_vld), .in_r_TREADY(trdy_v[g]),
            .out_r_TDATA(odat_v[g]), .out_r_TVALID(ovld_v[g]), .out_r_TREADY(out_rdy),
            .ke_start(ke_start_g), .ke_key(ke_key_g), .ke_rk_valid(ke_rk_valid_g),
            .ke_rk_idx(ke_rk_idx_g), .ke_rk_data(ke_rk_data_g), .ke_done(ke_done_g),
            .rd_din(rd_din_g), .rd_rk(rd_rk_g), .rd_final(rd_final_g), .rd_dout(rd_dout_g)
        );

        always_comb rd_dout_g = inv_round(rd_din_g, rd_rk_g, rd_final_g);

        // Expander: a junk write to index 15, then keys NR..0, done with the last write.
        initial begin
            ke_rk_valid_g = 1'b0; ke_rk_idx_g = '0; ke_rk_data_g = '0; ke_done_g = 1'b0;
            forever begin
                @(posedge ap_clk); #2;
                if (ke_start_g) begin
                    logic [255:0] kk;
                    kk = 256'(ke_key_g) << (256 - KB);
                    ke_rk_valid_g = 1'b1; ke_rk_idx_g = 4'd15; ke_rk_data_g = rand128();
                    for (int i = 0; i <= NRG; i++) begin
                        @(posedge ap_clk); #2;
                        ke_rk_idx_g  = 4'(NRG - i);
                        ke_rk_data_g = rk_of(kk, KB/32, NRG - i);
                        ke_done_g    = (i == NRG);
                    end
                    @(posedge ap_clk); #2;
                    ke_rk_valid_g = 1'b0; ke_done_g = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge ap_clk); #1;
        steps++;
        if (kst_v[sel]) kst_cnt++;
        if (done_v[sel]) begin
            if (done_cnt == 0) first_done = steps;
            done_cnt++;
        end
        if (ready_v[sel]) ready_cnt++;
        if (trdy_v[sel]) trdy_seen = 1'b1;
    endtask

    // mode: 0 = out ready always, 1 = toggle every cycle, 2 = random
    task automatic run_job(input int nb, input logic [255:0] k, input int mode, input bit gaps);
        int t, sent, got, hs_t, exp_kst, nr, budget, steps0;
        bit lat_pend, hold_pend;
        logic [127:0] held;
        nr = 10 + 2*sel;
        exp_kst = 0;
        if (nb > 0) begin
`ifdef AES_DEC_KEY_CACHE_EN
            if (!(cm_vld[sel] && cm_key[sel] == kview(k, sel))) exp_kst = 1;
`else
            exp_kst = 1;
`endif
            if (exp_kst == 1) begin
                cm_vld[sel] = 1'b1;
                cm_key[sel] = kview(k, sel);
            end
        end
        kst_cnt = 0; done_cnt = 0; ready_cnt = 0; trdy_seen = 1'b0; first_done = 0;
        steps0 = steps;
        key_in = k; num_blocks = CNT_W'(nb); ap_start = 1'b1;
        step();
        ap_start = 1'b0; key_in = rand256(); num_blocks = CNT_W'($urandom);
        sent = 0; got = 0; hs_t = 0; lat_pend = 0; hold_pend = 0; held = '0; t = 1;
        budget = 60 + nb*(nr+2)*6;
        while (done_cnt == 0 && t < budget) begin
            in_vld   = (sent < nb) && (!gaps || $urandom_range(0, 2) != 0);
            in_dat   = in_vld ? ct_q[sent] : rand128();
            out_rdy  = (mode == 0) ? 1'b1 : (mode == 1) ? t[0] : 1'($urandom_range(0, 1));
            ap_start = ($urandom_range(0, 5) == 0);
            if (hold_pend) begin
                vec++;
                if (ovld_v[sel] !== 1'b1 || odat_v[sel] !== held) begin
                    err++;
                    $display("FAIL stall_hold sel=%0d: valid=%b data=%h, required valid=1 data=%h", sel, ovld_v[sel], odat_v[sel], held);
                end
            end
            hold_pend = 0;
            if (in_vld && trdy_v[sel]) begin
                hs_t = t; sent++; lat_pend = 1;
            end
            if (ovld_v[sel]) begin
                if (lat_pend) begin
                    vec++;
                    if (t - hs_t != nr + 1) begin
                        err++;
                        $display("FAIL latency sel=%0d: %0d cycles, required %0d", sel, t - hs_t, nr + 1);
                    end
                    lat_pend = 0;
                end
                if (out_rdy) begin
                    vec++;
                    if (got >= nb || odat_v[sel] !== exp_q[got]) begin
                        err++;
                        $display("FAIL data sel=%0d blk=%0d: got %h, required %h", sel, got, odat_v[sel], (got < nb) ? exp_q[got] : 128'h0);
                    end
                    got++;
                end else begin
                    hold_pend = 1; held = odat_v[sel];
                end
            end
            step();
            t++;
        end
        ap_start = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        vec++;
        if (done_cnt != 1) begin err++; $display("FAIL done_count sel=%0d: %0d, required 1", sel, done_cnt); end
        vec++;
        if (got != nb) begin err++; $display("FAIL block_count sel=%0d: %0d, required %0d", sel, got, nb); end
        vec++;
        if (kst_cnt != exp_kst) begin err++; $display("FAIL ke_start_count sel=%0d: %0d, required %0d", sel, kst_cnt, exp_kst); end
        vec++;
        if (ready_cnt != 1) begin err++; $display("FAIL ap_ready_count sel=%0d: %0d, required 1", sel, ready_cnt); end
        if (nb == 0) begin
            vec++;
            if (first_done - steps0 > 3 || trdy_seen) begin
                err++;
                $display("FAIL zero_job: done after %0d cycles tready_seen=%b, required <=3 and 0", first_done - steps0, trdy_seen);
            end
        end
        step(); step();
        vec++;
        if (idle_v[sel] !== 1'b1 || done_cnt != 1 || ready_cnt != 1) begin
            err++;
            $display("FAIL idle_after sel=%0d: idle=%b done=%0d ready=%0d, required 1/1/1", sel, idle_v[sel], done_cnt, ready_cnt);
        end
    endtask

    task automatic fill_random(input int nb, input logic [255:0] k);
        logic [127:0] c;
        ct_q.delete(); exp_q.delete();
        for (int i = 0; i < nb; i++) begin
            c = rand128();
            ct_q.push_back(c);
            exp_q.push_back(aes_dec_ref(c, k, 4 + 2*sel));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ap_clk);
        #1;
        vec++;
        if (idle_v !== 3'b111 || done_v !== 3'b000 || ready_v !== 3'b000 || trdy_v !== 3'b000 || ovld_v !== 3'b000 || kst_v !== 3'b000) begin
            err++;
            $display("FAIL reset_state: idle=%b done=%b ready=%b trdy=%b ovld=%b kst=%b, required 111/000/000/000/000/000", idle_v, done_v, ready_v, trdy_v, ovld_v, kst_v);
        end
        ap_rst = 1'b0;
        step();
        vec++;
        if (idle_v !== 3'b111 || ovld_v !== 3'b000) begin
            err++;
            $display("FAIL post_reset_idle: idle=%b ovld=%b, required 111/000", idle_v, ovld_v);
        end
    endtask

    task automatic test_fips();
        logic [127:0] fct [3];
        fct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        fct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        fct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            ct_q.delete(); exp_q.delete();
            ct_q.push_back(fct[s]); exp_q.push_back(FPT);
            run_job(1, FKEY, 0, 1'b0);
        end
    endtask

    task automatic test_stall();
        logic [255:0] k;
        sel = 1; k = rand256();
        fill_random(3, k);
        run_job(3, k, 1, 1'b0);
    endtask

    task automatic test_zero_blocks();
        sel = 2;
        ct_q.delete(); exp_q.delete();
        run_job(0, rand256(), 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [255:0] k;
        sel = 0; k = rand256();
        fill_random(1, k); run_job(1, k, 0, 1'b0);
        fill_random(2, k); run_job(2, k, 0, 1'b0);
        k = rand256();
        fill_random(1, k); run_job(1, k, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [255:0] pool [2];
        logic [255:0] k;
        int nb;
        pool[0] = FKEY; pool[1] = rand256();
        for (int j = 0; j < 6; j++) begin
            sel = $urandom_range(0, 2);
            k   = ($urandom_range(0, 3) == 0) ? rand256() : pool[$urandom_range(0, 1)];
            nb  = $urandom_range(1, 3);
            fill_random(nb, k);
            run_job(nb, k, 2, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        int vcnt;
        sel = 2;
        key_in = rand256(); num_blocks = CNT_W'(2); ap_start = 1'b1;
        step();
        ap_start = 1'b0; in_vld = 1'b1; in_dat = rand128();
        w = 0;
        while (trdy_v[sel] !== 1'b1 && w < 100) begin step(); w++; end
        vec++;
        if (w >= 100) begin err++; $display("FAIL reset_mid_wait: tready not seen in %0d cycles, required <100", w); end
        step();
        in_vld = 1'b0;
        step(); step();
        ap_rst = 1'b1;
        #1;
        vec++;
        if (ovld_v[sel] !== 1'b0 || idle_v[sel] !== 1'b1 || trdy_v[sel] !== 1'b0) begin
            err++;
            $display("FAIL reset_mid_state: ovld=%b idle=%b trdy=%b, required 0/1/0", ovld_v[sel], idle_v[sel], trdy_v[sel]);
        end
        for (int s = 0; s < 3; s++) cm_vld[s] = 1'b0;
        step(); step();
        ap_rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin step(); if (ovld_v[sel]) vcnt++; end
        vec++;
        if (vcnt != 0 || idle_v[sel] !== 1'b1) begin
            err++;
            $display("FAIL reset_mid_drop: %0d output cycles idle=%b, required 0 and 1", vcnt, idle_v[sel]);
        end
        fill_random(2, FKEY);
        run_job(2, FKEY, 0, 1'b0);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin cm_vld[s] = 1'b0; cm_key[s] = '0; end
        kst_cnt = 0; done_cnt = 0; ready_cnt = 0; trdy_seen = 1'b0; first_done = 0;
        test_reset();
        test_fips();
        test_stall();
        test_zero_blocks();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/aes_dec_stream_ctrl.md
AES_DEC_STREAM_CTRL -- requirements
Module: aes_dec_stream_ctrl

Interface
REQ-001 SHALL provide parameter KEY_BITS, default 192; legal values 128/192/256, which select the AES key size.
REQ-002 SHALL derive NR = 10/12/14 from KEY_BITS (number of rounds).
REQ-003 SHALL have parameter CNT_W, default 16; it sets the width of the block counter.
REQ-004 Ports, listed as name, direction, width, meaning:
- ap_clk  in  1  the single clock.
- ap_rst  in  1  reset: asynchronous assert, active-high.
- ap_start  in  1  job request.
- ap_done  out  1  job-complete pulse.
- ap_idle  out  1  high in IDLE.
- ap_ready  out  1  job accepted.
- key  in  KEY_BITS  cipher key.
- num_blocks  in  CNT_W  blocks per job.
- in_r_TDATA  in  128  ciphertext.
- in_r_TVALID  in  1  input valid.
- in_r_TREADY  out  1  input ready.
- out_r_TDATA  out  128  plaintext.
- out_r_TVALID  out  1  output valid.
- out_r_TREADY  in  1  output ready.
- ke_start  out  1  key-expander start pulse.
- ke_key  out  KEY_BITS  key sent to the expander.
- ke_rk_valid  in  1  round-key write strobe.
- ke_rk_idx  in  4  round-key index 0..NR.
- ke_rk_data  in  128  round key.
- ke_done  in  1  expansion finished.
- rd_din  out  128  state sent to the inverse-round core.
- rd_rk  out  128  round key sent to the inverse-round core.
- rd_final  out  1  high on the last round (skip InvMixColumns).
- rd_dout  in  128  combinational result from the core.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high, ports ap_clk and ap_rst.

Function
REQ-006 SHALL implement FSM states IDLE, KEXP, LOAD, ROUND, OUT, DONE.
REQ-007 IDLE: ap_idle=1. When ap_start=1, SHALL do all of the following:
- latch key and num_blocks;
- pulse ap_ready for one cycle;
- go to KEXP, or to DONE if num_blocks=0.
REQ-008 KEXP: SHALL drive ke_start=1 for exactly the first cycle and hold ke_key = latched key.
REQ-009 KEXP: SHALL write ke_rk_data into the internal round-key file entry ke_rk_idx on each ke_rk_valid; idx>NR is ignored.
REQ-010 KEXP: on ke_done SHALL go to LOAD; if ke_rk_valid and ke_done occur in the same cycle, the write SHALL still take effect.
REQ-011 LOAD: in_r_TREADY=1. On the in_r_TVALID&in_r_TREADY handshake SHALL set state <= in_r_TDATA ^ rk[NR], set r <= NR-1, and go to ROUND.
REQ-012 in_r_TREADY SHALL be 0 in every state other than LOAD.
REQ-013 ROUND: each cycle SHALL drive:
- rd_din = state;
- rd_rk = rk[r];
- rd_final = (r==0).
It SHALL then set state <= rd_dout and decrement r. After the r=0 cycle it SHALL go to OUT. ROUND lasts exactly NR cycles.
REQ-014 OUT: out_r_TVALID=1 and out_r_TDATA=state, held stable until out_r_TREADY=1.
REQ-015 On the OUT handshake SHALL decrement the remaining-block counter, then:
- go to LOAD if the counter is still >0;
- otherwise go to DONE.
REQ-016 Latency from input handshake to out_r_TVALID SHALL be NR+1 cycles; throughput is one block per NR+2 cycles with no backpressure.
REQ-017 DONE: SHALL pulse ap_done for one cycle, then go to IDLE.
REQ-018 ap_start seen in any non-IDLE state SHALL be ignored, and key/num_blocks changes mid-job SHALL have no effect.
REQ-019 rd_din, rd_rk and rd_final SHALL be don't-care outside ROUND and SHALL NOT affect state.

Reset
REQ-020 Asserting ap_rst SHALL asynchronously force:
- FSM to IDLE;
- ap_done, ap_ready, ke_start, in_r_TREADY and out_r_TVALID to 0;
- the counters and the key-cache valid flag to 0.
REQ-021 Reset mid-job SHALL drop any in-flight block with no output. The round-key file contents need no reset.
REQ-022 The first cycle after reset deassertion SHALL be IDLE, with ap_idle=1.

Configuration
REQ-023 Macro AES_DEC_KEY_CACHE_EN.
REQ-024 When AES_DEC_KEY_CACHE_EN is defined:
- SHALL keep a copy of the last fully expanded key plus a valid flag;
- at job start, if the flag is set and the latched key equals the cached key, SHALL skip KEXP (IDLE->LOAD) and issue no ke_start;
- the flag SHALL be set on ke_done.
REQ-025 When AES_DEC_KEY_CACHE_EN is undefined: every job with num_blocks>0 SHALL pass through KEXP.

Verification
REQ-026 KEY_BITS=192, key 000102..1617, num_blocks=1, input dda97ca4864cdfe06eaf70a0ec0d7191 (FIPS-197 C.2), behavioural expander and core models -> out_r_TDATA 00112233445566778899aabbccddeeff, seen 13 cycles after the input handshake.
REQ-027 KEY_BITS=128 and 256 with the FIPS-197 C.1/C.3 vectors -> plaintext 00112233..eeff, latency 11 and 15 cycles respectively.
REQ-028 num_blocks=3 with out_r_TREADY toggled 1/0 every cycle -> 3 correct blocks in order, TDATA stable while stalled, a single ap_done after the third block.
REQ-029 num_blocks=0 -> ap_ready then ap_done within 3 cycles, no ke_start, in_r_TREADY never 1.
REQ-030 Two back-to-back jobs with the same key:
- with AES_DEC_KEY_CACHE_EN -> exactly 1 ke_start in total;
- without it -> 2 ke_start;
- with a changed key under AES_DEC_KEY_CACHE_EN -> 2 ke_start.
REQ-031 ap_rst asserted during ROUND -> out_r_TVALID=0 immediately and the FSM in IDLE; the next job produces correct output.
